// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: state encoding, bus direction constants and width/parity helpers
// shared by the serial bus slaves.
package serial_bus_pkg;
  typedef enum logic [2:0] {IDLE, WR_SHIFT, RD_FETCH, RD_SHIFT, ERR, DONE} state_e;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: LSB-first word shift register with bit counter; last_bit_o marks the
// final bit slot of a word (the parity slot when PAR=1).
module serial_shifter
  import serial_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAR        = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_val_i,
  input  logic                  shift_i,
  input  logic                  ser_i,
  output logic                  ser_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  last_bit_o,
  output logic                  par_slot_o
);
  localparam int CW = clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH + PAR - 1);
  logic [DATA_WIDTH-1:0] sr_q, sr_nx;
  logic [CW-1:0] cnt_q;
  assign sr_nx = {ser_i, sr_q[DATA_WIDTH-1:1]};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_val_i;
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (shift_i) begin
      cnt_q <= last_bit_o ? '0 : cnt_q + 1'b1;
      if (cnt_q < DW_C) sr_q <= sr_nx;
    end
  end
  // With parity the word is complete before the parity slot; without it the MSB arrives on the last edge.
  assign wdata_o    = (PAR != 0) ? sr_q : sr_nx;
  assign ser_o      = sr_q[0];
  assign last_bit_o = cnt_q == LAST;
  assign par_slot_o = (PAR != 0) && cnt_q == DW_C;
endmodule

// File: rtl/serial_burst_slave.sv
// serial_burst_slave: memory-backed serial bus slave moving bursts bit-serially, LSB first.
// Optional even parity per word when SERIAL_SLAVE_PARITY_EN is defined.
module serial_burst_slave
  import serial_bus_pkg::*;
#(
  parameter int MEM_OFFSET    = 0,
  parameter int MEM_SIZE      = 2048,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sel,
  input  logic                     rw_select,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [BURST_WIDTH-1:0]   burst_len,
  input  logic                     data_in_serial,
  output logic                     data_out_serial,
  output logic                     data_out_en,
  output logic                     ready,
  output logic                     done,
  output logic                     error
);
  localparam int MW = clog2(MEM_SIZE);
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  state_e state_q, state_d;
  logic [MW-1:0] la_q, la_d, la_inc;
  logic [BURST_WIDTH-1:0] wc_q, wc_d, bl_q, bl_d;
  logic ready_q, perr_q, perr_d, we, sh_clr, sh_load, sh_shift;
  logic sh_ser, sh_last, sh_par_slot, par_q, par_bad, in_range;
  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] sh_wdata, rd_word;
  logic [32:0] diff;
  // Borrow bit of the subtraction flags addresses below the window.
  assign diff     = {1'b0, 32'(addr_in)} - 33'(MEM_OFFSET);
  assign in_range = !diff[32] && diff[31:0] < 32'(MEM_SIZE);
  assign la_inc   = (la_q == MW'(MEM_SIZE - 1)) ? '0 : la_q + 1'b1;
  assign rd_word  = mem_q[la_q];
  serial_shifter #(.DATA_WIDTH(DATA_WIDTH), .PAR(PAR)) u_shifter (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (sh_clr),
    .load_i     (sh_load),
    .load_val_i (rd_word),
    .shift_i    (sh_shift),
    .ser_i      (data_in_serial),
    .ser_o      (sh_ser),
    .wdata_o    (sh_wdata),
    .last_bit_o (sh_last),
    .par_slot_o (sh_par_slot)
  );
`ifdef SERIAL_SLAVE_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) par_q <= 1'b0;
    else if (sh_load) par_q <= parity(64'(rd_word));
  end
  assign par_bad = parity(64'(sh_wdata)) ^ data_in_serial;
`else
  assign par_q   = 1'b0;
  assign par_bad = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    la_d     = la_q;
    wc_d     = wc_q;
    bl_d     = bl_q;
    perr_d   = perr_q;
    we       = 1'b0;
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    case (state_q)
      IDLE: if (ready_q && sel) begin
        la_d    = MW'(diff);
        bl_d    = burst_len;
        wc_d    = '0;
        perr_d  = 1'b0;
        sh_clr  = 1'b1;
        state_d = !in_range ? ERR : (rw_select == RW_WRITE) ? WR_SHIFT : RD_FETCH;
      end
      WR_SHIFT: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          we     = !par_bad;
          perr_d = perr_q | par_bad;
          la_d   = la_inc;
          wc_d   = wc_q + 1'b1;
          if (wc_q == bl_q) state_d = DONE;
        end
      end
      RD_FETCH: begin
        sh_load = 1'b1;
        la_d    = la_inc;
        state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        sh_shift = 1'b1;
        // Reload on the last bit slot so consecutive words leave no gap.
        if (sh_last) begin
          if (wc_q == bl_q) state_d = DONE;
          else begin
            sh_load = 1'b1;
            la_d    = la_inc;
            wc_d    = wc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !sel) begin
      state_d = IDLE;
      we      = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      la_q    <= '0;
      wc_q    <= '0;
      bl_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == IDLE;
      la_q    <= la_d;
      wc_q    <= wc_d;
      bl_q    <= bl_d;
      perr_q  <= perr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[la_q] <= sh_wdata;
  end
  assign ready           = ready_q;
  assign done            = state_q == DONE || state_q == ERR;
  assign error           = state_q == ERR || (state_q == DONE && perr_q);
  assign data_out_en     = state_q == RD_SHIFT;
  assign data_out_serial = data_out_en && (sh_par_slot ? par_q : sh_ser);
endmodule

// File: tb/tb_serial_burst_slave.sv
// tb_serial_burst_slave: vector table, hand sequences and randomized bursts checked
// against a word-level memory model.
module tb_serial_burst_slave;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int DW = 8, OFF = 1024, SZ = 256, W = DW + PAR;
  logic clk = 1'b0, rstn, sel, rw_select, data_in_serial;
  logic [11:0] addr_in;
  logic [3:0] burst_len;
  logic data_out_serial, data_out_en, ready, done, error;
  serial_burst_slave #(
    .MEM_OFFSET(OFF), .MEM_SIZE(SZ), .ADDRESS_WIDTH(12), .DATA_WIDTH(DW), .BURST_WIDTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .rw_select(rw_select), .addr_in(addr_in),
    .burst_len(burst_len), .data_in_serial(data_in_serial), .data_out_serial(data_out_serial),
    .data_out_en(data_out_en), .ready(ready), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rw;
    int addr;
    int bl;
    logic [31:0] wds;
    int exp_done;
    int exp_err;
  } vec_t;
  vec_t vt[8];
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mm[SZ];
  logic [7:0] wbuf[16], rbuf[16];
  logic pbuf[16];
  bit badp[16];
  int r_done_n, r_err_n, r_done_cyc, r_err_cyc, r_en_n, r_en_first, r_post;
  logic r_ready_after;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input bit rw, input int addr, input int bl, input int ab);
    int c, tot, s;
    logic b;
    tot = (bl + 1) * W;
    r_done_n = 0; r_err_n = 0; r_done_cyc = -1; r_err_cyc = -1;
    r_en_n = 0; r_en_first = -1; r_post = 0;
    for (int i = 0; i < 16; i++) begin
      rbuf[i] = 'x;
      pbuf[i] = 1'bx;
    end
    for (int i = 0; i < 30 && ready !== 1'b1; i++) step();
    chk("ready_wait", 32'(ready), 1);
    sel = 1'b1; rw_select = rw; addr_in = 12'(addr); burst_len = 4'(bl);
    step();
    c = 1;
    forever begin
      if (data_out_en === 1'b1) begin
        if (r_en_n == 0) r_en_first = c;
        s = r_en_n;
        if (s / W < 16) begin
          if (s % W < DW) rbuf[s/W][s%W] = data_out_serial;
          else pbuf[s/W] = data_out_serial;
        end
        r_en_n++;
      end
      if (done === 1'b1) begin r_done_n++; r_done_cyc = c; end
      if (error === 1'b1) begin r_err_n++; r_err_cyc = c; end
      if (ab >= 0 && c == ab + 1) begin sel = 1'b0; step(); break; end
      if (done === 1'b1) begin step(); sel = 1'b0; break; end
      if (c > tot + 4) begin
        sel = 1'b0; step();
        chk("done_timeout", r_done_n, 1);
        break;
      end
      s = c - 1;
      b = (s < tot) ? ((s % W < DW) ? wbuf[s/W][s%W] : ((^wbuf[s/W]) ^ badp[s/W])) : 1'b0;
      data_in_serial = rw ? b : 1'($urandom);
      step();
      c++;
    end
    r_ready_after = ready;
    r_post = 32'({data_out_en, done, error});
    data_in_serial = 1'b0;
  endtask
  task automatic xfer(input bit rw, input int addr, input int bl, input int ab);
    int tot, nw, la;
    bit inr, anyb;
    tot = (bl + 1) * W;
    inr = addr >= OFF && addr < OFF + SZ;
    nw = 0;
    run(rw, addr, bl, ab);
    chk("ready_after_end", 32'(r_ready_after), 1);
    chk("outputs_after_end", r_post, 0);
    if (!inr) begin
      chk("range_err_n", r_err_n, 1);
      chk("range_done_n", r_done_n, 1);
      chk("range_done_cyc", r_done_cyc, 1);
      chk("range_en_n", r_en_n, 0);
    end else if (ab >= 0) begin
      chk("abort_done_n", r_done_n, 0);
      chk("abort_err_n", r_err_n, 0);
      chk("abort_en_n", r_en_n, rw ? 0 : ab);
      nw = rw ? ab / W : 0;
    end else begin
      anyb = 1'b0;
      for (int w = 0; w <= bl; w++) if (rw && badp[w]) anyb = 1'b1;
      chk("done_n", r_done_n, 1);
      chk("done_cyc", r_done_cyc, tot + (rw ? 1 : 2));
      chk("err_n", r_err_n, anyb ? 1 : 0);
      if (anyb) chk("err_with_done", r_err_cyc, r_done_cyc);
      chk("en_n", r_en_n, rw ? 0 : tot);
      if (!rw) begin
        chk("en_first", r_en_first, 2);
        for (int w = 0; w <= bl; w++) begin
          la = (addr - OFF + w) % SZ;
          chk("rd_word", 32'(rbuf[w]), 32'(mm[la]));
`ifdef SERIAL_SLAVE_PARITY_EN
          chk("rd_parity", 32'(pbuf[w]), 32'(^mm[la]));
`endif
        end
      end
      nw = rw ? bl + 1 : 0;
    end
    if (inr) for (int w = 0; w < nw; w++) if (!badp[w]) mm[(addr - OFF + w) % SZ] = wbuf[w];
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] old;
    int bl, ab;
    bit rw;
    vt[0] = '{1'b1, 1040, 0, 32'h000000A5, W + 1, 0};
    vt[1] = '{1'b0, 1040, 0, 32'h000000A5, W + 2, 0};
    vt[2] = '{1'b1, 1278, 3, 32'h44332211, 4 * W + 1, 0};
    vt[3] = '{1'b0, 1278, 3, 32'h44332211, 4 * W + 2, 0};
    vt[4] = '{1'b1, 1023, 0, 32'h0, 1, 1};
    vt[5] = '{1'b0, 1280, 2, 32'h0, 1, 1};
    vt[6] = '{1'b1, 1280, 0, 32'h0, 1, 1};
    vt[7] = '{1'b0, 1040, 0, 32'h000000A5, W + 2, 0};
    for (int i = 0; i < 16; i++) badp[i] = 1'b0;
    rstn = 1'b0; sel = 1'b0; rw_select = 1'b0; addr_in = '0; burst_len = '0; data_in_serial = 1'b0;
    step();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_dout", 32'(data_out_serial), 0);
    chk("rst_dout_en", 32'(data_out_en), 0);
    step();
    rstn = 1'b1;
    step();
    chk("ready_first_edge", 32'(ready), 1);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      xfer(1'b1, OFF + 16 * k, 15, -1);
    end
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < 4; w++) wbuf[w] = vt[i].wds[8*w +: 8];
      xfer(vt[i].rw, vt[i].addr, vt[i].bl, -1);
      chk("vec_done_cyc", r_done_cyc, vt[i].exp_done);
      chk("vec_err_n", r_err_n, vt[i].exp_err);
      if (!vt[i].rw && vt[i].exp_err == 0)
        for (int w = 0; w <= vt[i].bl; w++) chk("vec_rd_word", 32'(rbuf[w]), 32'(vt[i].wds[8*w +: 8]));
    end
    old = mm[77];
    wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
    xfer(1'b1, 1100, 1, 12);
    xfer(1'b0, 1100, 1, -1);
    chk("abort_word0", 32'(rbuf[0]), 32'h C3);
    chk("abort_word1", 32'(rbuf[1]), 32'(old));
    for (int i = 0; i < 30 && ready !== 1'b1; i++) step();
    sel = 1'b1; rw_select = 1'b0; addr_in = 12'd1100; burst_len = 4'd1;
    for (int i = 0; i < 5; i++) step();
    chk("rd_en_before_rst", 32'(data_out_en), 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_en", 32'(data_out_en), 0);
    chk("rst_mid_ready", 32'(ready), 0);
    chk("rst_mid_done", 32'(done), 0);
    sel = 1'b0;
    step();
    chk("rst_hold_ready", 32'(ready), 0);
    rstn = 1'b1;
    step();
    chk("ready_after_rst", 32'(ready), 1);
    xfer(1'b0, 1100, 1, -1);
    chk("mem_after_rst", 32'(rbuf[0]), 32'h C3);
`ifdef SERIAL_SLAVE_PARITY_EN
    wbuf[0] = 8'h07; badp[0] = 1'b1;
    xfer(1'b1, 1200, 0, -1);
    chk("par_bad_err", r_err_n, 1);
    chk("par_bad_err_cyc", r_err_cyc, r_done_cyc);
    badp[0] = 1'b0;
    xfer(1'b1, 1200, 0, -1);
    xfer(1'b0, 1200, 0, -1);
    chk("par_rd_word", 32'(rbuf[0]), 32'h07);
    chk("par_rd_bit", 32'(pbuf[0]), 1);
`endif
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom);
      bl = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = 8'($urandom);
`ifdef SERIAL_SLAVE_PARITY_EN
        badp[i] = ($urandom_range(0, 7) == 0);
`endif
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (bl + 1) * W - 1)) : -1;
      xfer(rw, int'($urandom_range(OFF - 8, OFF + SZ + 8)), bl, ab);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
